// File: rtl/jpeg_frame_wrapper.sv
// -----------------------------------------------------------------------------
// jpeg_frame_wrapper
//
// Wraps one compressed frame from jfpjc into a complete JFIF byte stream:
//   header bytes from the header EBR, with a 64-byte quantization table from
//   the quant EBR spliced in at QUANT_OFFSET, then the buffered scan bytes,
//   then the EOI marker 0xFF 0xD9. The output is a single registered byte
//   slot with valid/ready backpressure.
//
// Optional feature macro: JPEG_FRAME_BYTE_COUNT_EN
//   defined   -> frame_bytes reports the total bytes (EOI included) of the
//                last completed frame, updated on the frame_done cycle.
//   undefined -> frame_bytes is tied to zero.
//
// Ports:
//   clock, nreset          clock, asynchronous active-low reset
//   frame_start            one-cycle pulse, starts a frame (ignored unless idle)
//   frame_end              one-cycle pulse, compressor has sent its last byte
//   in_valid, in_data      compressor byte strobe and byte (jfpjc hsync/data_out)
//   header_ebr_*           header EBR read port (dout valid 1 cycle after ren)
//   quant_ebr_*            quant-table EBR read port (dout valid 1 cycle after ren)
//   out_valid/ready/data   output byte stream to the downstream sink
//   frame_done             one-cycle pulse after 0xD9 is accepted
//   overflow               sticky, a scan byte was dropped this frame
//   busy                   a frame is in progress
//   frame_bytes            byte count of the last frame (see macro above)
//
// The EBRs are assumed to hold their last read data while ren is low; a
// header read whose byte cannot enter the stalled slot simply waits on dout.
// -----------------------------------------------------------------------------
module jpeg_frame_wrapper #(
    parameter int HEADER_LEN   = 328,
    parameter int HEADER_AW    = 9,
    parameter int QUANT_OFFSET = 25,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 frame_start,
    input  logic                 frame_end,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    output logic [HEADER_AW-1:0] header_ebr_raddr,
    output logic                 header_ebr_ren,
    input  logic [DATA_W-1:0]    header_ebr_dout,
    output logic [5:0]           quant_ebr_raddr,
    output logic                 quant_ebr_ren,
    input  logic [DATA_W-1:0]    quant_ebr_dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 frame_done,
    output logic                 overflow,
    output logic                 busy,
    output logic [31:0]          frame_bytes
);

    localparam int IW        = HEADER_AW + 1;   // index width, can hold HEADER_LEN
    localparam int FAW       = $clog2(FIFO_DEPTH);
    localparam int QUANT_LEN = 64;

    generate
        if (DATA_W != 8) begin : g_bad_data_w
            $error("jpeg_frame_wrapper: DATA_W must be 8");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("jpeg_frame_wrapper: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        BODY,
        EOI0,
        EOI1
    } state_t;

    state_t              state;
    logic [IW-1:0]       issue_idx;     // next header index to read
    logic                rd_pend;       // a header/quant read is waiting to enter the slot
    logic                rd_quant;      // source of the pending read (pipelined select)
    logic                end_latch;     // frame_end seen during this frame

    logic                slot_free;
    logic                xfer;
    logic                start_frame;
    logic [IW-1:0]       rd_idx;
    logic                in_quant;
    logic                hdr_load;
    logic                hdr_issue;
    logic [DATA_W-1:0]   hdr_byte;

    // Scan FIFO: pointers carry one extra MSB to tell full from empty.
    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [FAW:0]        wr_ptr;
    logic [FAW:0]        rd_ptr;
    logic                fifo_empty;
    logic                fifo_full;
    logic                fifo_push;
    logic                fifo_pop;
    logic                in_drop;

    always_comb begin
        slot_free   = !out_valid || out_ready;
        xfer        = out_valid && out_ready;
        start_frame = (state == IDLE) && frame_start;

        // The read for header byte 0 is issued on the frame_start cycle itself,
        // so the first byte reaches the slot two cycles after frame_start.
        rd_idx   = (state == IDLE) ? '0 : issue_idx;
        in_quant = (rd_idx >= IW'(QUANT_OFFSET)) &&
                   (rd_idx <  IW'(QUANT_OFFSET + QUANT_LEN));

        // A pending read enters the slot only when the slot is free; a new read
        // is issued only when no read is pending or the pending one leaves now,
        // so dout is never overwritten before it has been used.
        hdr_load  = (state == HDR) && rd_pend && slot_free;
        hdr_issue = start_frame ||
                    ((state == HDR) && (issue_idx < IW'(HEADER_LEN)) &&
                     (!rd_pend || hdr_load));

        header_ebr_ren   = hdr_issue && !in_quant;
        quant_ebr_ren    = hdr_issue && in_quant;
        header_ebr_raddr = header_ebr_ren ? rd_idx[HEADER_AW-1:0] : '0;
        quant_ebr_raddr  = quant_ebr_ren ? 6'(rd_idx - IW'(QUANT_OFFSET)) : '0;
        hdr_byte         = rd_quant ? quant_ebr_dout : header_ebr_dout;

        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[FAW] != rd_ptr[FAW]) &&
                     (wr_ptr[FAW-1:0] == rd_ptr[FAW-1:0]);
        fifo_pop   = (state == BODY) && !fifo_empty && slot_free;
        // A push into a full FIFO still succeeds when a pop frees a slot now.
        fifo_push  = in_valid && ((state == HDR) || (state == BODY)) &&
                     (!fifo_full || fifo_pop);
        in_drop    = in_valid && !fifo_push;
    end

    assign busy = (state != IDLE);

    // NOTE: storage arrays carry no reset; the pointers alone define contents.
    always_ff @(posedge clock) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr[FAW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (start_frame) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every branch sees
    // the pre-edge values, which the slot/read handshake depends on.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            issue_idx  <= '0;
            rd_pend    <= 1'b0;
            rd_quant   <= 1'b0;
            end_latch  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // An accepted byte empties the slot unless a new byte loads below.
            if (xfer) out_valid <= 1'b0;

            if (start_frame)  overflow <= 1'b0;
            else if (in_drop) overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_frame) begin
                        state     <= HDR;
                        issue_idx <= IW'(1);
                        rd_pend   <= 1'b1;
                        rd_quant  <= in_quant;
                        end_latch <= 1'b0;
                    end
                end

                HDR: begin
                    if (frame_end) end_latch <= 1'b1;
                    if (hdr_load) begin
                        out_valid <= 1'b1;
                        out_data  <= hdr_byte;
                    end
                    if (hdr_issue) begin
                        issue_idx <= issue_idx + 1'b1;
                        rd_pend   <= 1'b1;
                        rd_quant  <= in_quant;
                    end else if (hdr_load) begin
                        rd_pend   <= 1'b0;
                    end
                    // Everything issued and loaded, and the slot drains now.
                    if ((issue_idx == IW'(HEADER_LEN)) && !rd_pend && slot_free) begin
                        state <= BODY;
                    end
                end

                BODY: begin
                    if (frame_end) end_latch <= 1'b1;
                    if (fifo_pop) begin
                        out_valid <= 1'b1;
                        out_data  <= fifo_mem[rd_ptr[FAW-1:0]];
                    end else if (end_latch && fifo_empty && slot_free) begin
                        state <= EOI0;
                    end
                end

                EOI0: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= 8'hFF;
                    end else if (out_ready) begin
                        out_valid <= 1'b1;
                        out_data  <= 8'hD9;
                        state     <= EOI1;
                    end
                end

                EOI1: begin
                    if (xfer) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef JPEG_FRAME_BYTE_COUNT_EN
    logic [31:0] byte_cnt;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            byte_cnt    <= '0;
            frame_bytes <= '0;
        end else begin
            if (start_frame)  byte_cnt <= '0;
            else if (xfer)    byte_cnt <= byte_cnt + 32'd1;
            // The accepted 0xD9 is counted here, one ahead of byte_cnt.
            if ((state == EOI1) && xfer) frame_bytes <= byte_cnt + 32'd1;
        end
    end
`else
    assign frame_bytes = '0;
`endif

endmodule

// File: tb/tb_jpeg_frame_wrapper.sv
// -----------------------------------------------------------------------------
// tb_jpeg_frame_wrapper
//
// Scoreboard bench for jpeg_frame_wrapper. Expected bytes are queued as the
// stimulus is driven (header image, scan bytes, EOI) and compared in order
// against every accepted output byte. Header EBR holds i[7:0], quant EBR holds
// 0x80+a, both modelled as registered reads that hold dout while ren is low.
// -----------------------------------------------------------------------------
module tb_jpeg_frame_wrapper;

    localparam int HEADER_LEN   = 328;
    localparam int HEADER_AW    = 9;
    localparam int QUANT_OFFSET = 25;
    localparam int FIFO_DEPTH   = 16;
`ifdef JPEG_FRAME_BYTE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                 clock;
    logic                 nreset;
    logic                 frame_start;
    logic                 frame_end;
    logic                 in_valid;
    logic [7:0]           in_data;
    logic [HEADER_AW-1:0] header_ebr_raddr;
    logic                 header_ebr_ren;
    logic [7:0]           header_ebr_dout;
    logic [5:0]           quant_ebr_raddr;
    logic                 quant_ebr_ren;
    logic [7:0]           quant_ebr_dout;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_data;
    logic                 frame_done;
    logic                 overflow;
    logic                 busy;
    logic [31:0]          frame_bytes;

    int         checks   = 0;
    int         errors   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    int         popped   = 0;
    int         cyc      = 0;
    int         eoi_cyc  = -10;
    int         done_cnt = 0;
    bit         rnd_stop = 1'b0;

    jpeg_frame_wrapper #(
        .HEADER_LEN  (HEADER_LEN),
        .HEADER_AW   (HEADER_AW),
        .QUANT_OFFSET(QUANT_OFFSET),
        .DATA_W      (8),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clock           (clock),
        .nreset          (nreset),
        .frame_start     (frame_start),
        .frame_end       (frame_end),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .header_ebr_raddr(header_ebr_raddr),
        .header_ebr_ren  (header_ebr_ren),
        .header_ebr_dout (header_ebr_dout),
        .quant_ebr_raddr (quant_ebr_raddr),
        .quant_ebr_ren   (quant_ebr_ren),
        .quant_ebr_dout  (quant_ebr_dout),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .frame_done      (frame_done),
        .overflow        (overflow),
        .busy            (busy),
        .frame_bytes     (frame_bytes)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // EBR models: registered read, output held while ren is low.
    initial begin
        header_ebr_dout = 8'h00;
        quant_ebr_dout  = 8'h00;
    end
    always @(posedge clock) begin
        if (header_ebr_ren) header_ebr_dout <= 8'(header_ebr_raddr);
        if (quant_ebr_ren)  quant_ebr_dout  <= 8'(8'h80 + quant_ebr_raddr);
    end

    // Output monitor: a byte seen valid&ready here transfers on the next edge.
    always @(negedge clock) begin
        if (nreset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream: unexpected byte %02h, none expected", out_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (out_data !== exp_b) begin
                    errors++;
                    $display("FAIL stream byte %0d: got %02h expected %02h", popped, out_data, exp_b);
                end
                if (exp_q.size() == 0) eoi_cyc = cyc;
            end
            popped++;
        end
        if (nreset === 1'b1 && frame_done === 1'b1) begin
            checks++;
            done_cnt++;
            if (cyc != eoi_cyc + 1) begin
                errors++;
                $display("FAIL frame_done timing: at cycle %0d, expected cycle %0d", cyc, eoi_cyc + 1);
            end
        end
    end

    // ------------------------------------------------------------ helpers
    task automatic push_header();
        for (int i = 0; i < HEADER_LEN; i++) begin
            if (i >= QUANT_OFFSET && i < QUANT_OFFSET + 64)
                exp_q.push_back(8'(8'h80 + i - QUANT_OFFSET));
            else
                exp_q.push_back(8'(i));
        end
    endtask

    task automatic start_frame();
        @(posedge clock); #1 frame_start = 1'b1; popped = 0;
        @(posedge clock); #1 frame_start = 1'b0;
    endtask

    task automatic end_frame();
        @(posedge clock); #1 frame_end = 1'b1;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hD9);
        @(posedge clock); #1 frame_end = 1'b0;
    endtask

    task automatic push_scan(input logic [7:0] b);
        @(posedge clock); #1 in_valid = 1'b1; in_data = b;
        exp_q.push_back(b);
        @(posedge clock); #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (n < budget) begin
            @(negedge clock);
            if (frame_done === 1'b1) break;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s frame_done: not seen within %0d cycles", tag, budget);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s stream length: %0d bytes missing", tag, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic wait_popped(input int target, input int budget, input string tag);
        int n = 0;
        while (popped < target && n < budget) begin
            @(posedge clock);
            n++;
        end
        #1;
        if (popped < target) begin
            checks++;
            errors++;
            $display("FAIL %s progress: %0d bytes out, needed %0d", tag, popped, target);
        end
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        nreset = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({out_valid, frame_done, overflow, busy, header_ebr_ren, quant_ebr_ren} !== 6'b0) begin
            errors++;
            $display("FAIL reset flags: got %b expected 000000",
                     {out_valid, frame_done, overflow, busy, header_ebr_ren, quant_ebr_ren});
        end
        checks++;
        if (out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset out_data: got %02h expected 00", out_data);
        end
        checks++;
        if (header_ebr_raddr !== '0 || quant_ebr_raddr !== '0 || frame_bytes !== 32'd0) begin
            errors++;
            $display("FAIL reset addr/count: got %0d %0d %0d expected 0 0 0",
                     header_ebr_raddr, quant_ebr_raddr, frame_bytes);
        end
        @(posedge clock); #1 nreset = 1'b1;
    endtask

    task automatic test_empty_frame();
        out_ready = 1'b1;
        push_header();
        start_frame();
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL latency cycle1: out_valid=%b busy=%b expected 0 1", out_valid, busy);
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency cycle2: out_valid=%b expected 1", out_valid);
        end
        end_frame();
        wait_done(1000, "empty");
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL empty overflow: got %b expected 0", overflow);
        end
        checks++;
        if (frame_bytes !== (CNT_EN ? 32'd330 : 32'd0)) begin
            errors++;
            $display("FAIL empty frame_bytes: got %0d expected %0d", frame_bytes, CNT_EN ? 330 : 0);
        end
    endtask

    task automatic test_scan_in_hdr();
        out_ready = 1'b1;
        push_header();
        start_frame();
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1 in_valid = 1'b1; in_data = 8'(k);
            exp_q.push_back(8'(k));
            if (k == 10) begin
                frame_end = 1'b1;
                exp_q.push_back(8'hFF);
                exp_q.push_back(8'hD9);
            end
            @(posedge clock); #1 in_valid = 1'b0; frame_end = 1'b0;
        end
        wait_done(1000, "scan_hdr");
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL scan_hdr overflow: got %b expected 0", overflow);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        push_header();
        start_frame();
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + k);
            if (k < FIFO_DEPTH) exp_q.push_back(8'(8'h40 + k));
            @(posedge clock); #1;
            if (k == 15) begin
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL overflow at push 16: got %b expected 0", overflow);
                end
            end
            if (k == 16) begin
                checks++;
                if (overflow !== 1'b1) begin
                    errors++;
                    $display("FAIL overflow at push 17: got %b expected 1", overflow);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        end_frame();
        wait_done(1500, "overflow");
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow sticky: got %b expected 1", overflow);
        end
        checks++;
        if (frame_bytes !== (CNT_EN ? 32'd346 : 32'd0)) begin
            errors++;
            $display("FAIL overflow frame_bytes: got %0d expected %0d", frame_bytes, CNT_EN ? 346 : 0);
        end
        push_header();
        start_frame();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow clear on start: got %b expected 0", overflow);
        end
        end_frame();
        wait_done(1000, "after_overflow");
    endtask

    task automatic test_random();
        push_header();
        rnd_stop = 1'b0;
        start_frame();
        fork
            begin
                while (!rnd_stop) begin
                    @(posedge clock); #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
            begin
                wait_popped(HEADER_LEN, 5000, "random_hdr");
                for (int k = 0; k < 500; k++) begin
                    @(posedge clock); #1 in_valid = 1'b1; in_data = 8'(k * 37 + 5);
                    exp_q.push_back(8'(k * 37 + 5));
                    @(posedge clock); #1 in_valid = 1'b0;
                    repeat (2) @(posedge clock);
                end
                end_frame();
                wait_done(2000, "random");
                rnd_stop = 1'b1;
            end
        join
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL random overflow: got %b expected 0", overflow);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        push_header();
        start_frame();
        wait_popped(HEADER_LEN, 1000, "reset_mid_hdr");
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) push_scan(8'(8'hC0 + k));
        @(posedge clock); #1;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid pre-state: busy=%b out_valid=%b expected 1 1", busy, out_valid);
        end
        nreset = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if ({out_valid, frame_done, overflow, busy, header_ebr_ren, quant_ebr_ren} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid flags: got %b expected 000000",
                     {out_valid, frame_done, overflow, busy, header_ebr_ren, quant_ebr_ren});
        end
        checks++;
        if (out_data !== 8'h00 || frame_bytes !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid data/count: got %02h %0d expected 00 0", out_data, frame_bytes);
        end
        @(posedge clock); #1 nreset = 1'b1; out_ready = 1'b1;
        push_header();
        start_frame();
        end_frame();
        wait_done(1000, "after_reset");
    endtask

    task automatic test_ignored();
        int done_before;
        out_ready = 1'b1;
        @(posedge clock); #1 frame_end = 1'b1;
        @(posedge clock); #1 frame_end = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle frame_end: busy=%b out_valid=%b expected 0 0", busy, out_valid);
        end
        done_before = done_cnt;
        push_header();
        start_frame();
        wait_popped(HEADER_LEN, 1000, "ignored_hdr");
        for (int k = 0; k < 4; k++) push_scan(8'(8'hA0 + k));
        @(posedge clock); #1 frame_start = 1'b1;
        @(posedge clock); #1 frame_start = 1'b0;
        // Last scan byte coincides with frame_end.
        @(posedge clock); #1 in_valid = 1'b1; in_data = 8'h5A; frame_end = 1'b1;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hD9);
        @(posedge clock); #1 in_valid = 1'b0; frame_end = 1'b0;
        wait_done(1000, "ignored");
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done_cnt != done_before + 1) begin
            errors++;
            $display("FAIL ignored restart: busy=%b frames=%0d expected 0 %0d",
                     busy, done_cnt - done_before, 1);
        end
    endtask

    initial begin
        test_reset();
        test_empty_frame();
        test_scan_in_hdr();
        test_overflow();
        test_random();
        test_reset_mid();
        test_ignored();
        repeat (4) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
